csr_exec: RTL and testbench
===========================

CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 SHALL take parameter REG_W, default reg_defines::REG_W_END+1 (32), data width of CSR and register values.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  CSR instruction offered.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_funct3  input  3  Zicsr funct3: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI.
REQ-007 SHALL have port req_addr  input  12  CSR address.
REQ-008 SHALL have port req_rs1  input  REG_W  rs1 register value.
REQ-009 SHALL have port req_rs1_idx  input  5  rs1 index, which is also zimm.
REQ-010 SHALL have port req_rd  input  5  destination register index.
REQ-011 SHALL have port csr_addr  output  12  address to CSR file.
REQ-012 SHALL have port csr_wen  output  1  CSR write strobe.
REQ-013 SHALL have port csr_wdata  output  REG_W  CSR write data.
REQ-014 SHALL have port csr_rdata  input  REG_W  combinational CSR read data.
REQ-015 SHALL have port rsp_valid  output  1  result available.
REQ-016 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-017 SHALL have port rsp_rd  output  5  destination index.
REQ-018 SHALL have port rsp_data  output  REG_W  old CSR value for rd.
REQ-019 SHALL have port rsp_illegal  output  1  illegal-instruction flag.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-021 In IDLE, SHALL assert req_ready=1.
REQ-022 On req_valid&&req_ready, SHALL latch funct3, addr, rs1, rs1_idx, rd, and move to READ.
REQ-023 In all other states, SHALL hold req_ready=0.
REQ-024 In READ, SHALL drive csr_addr with the latched address, capture csr_rdata into old, and compute new.
REQ-025 SHALL compute new as follows, where src is rs1 (funct3[2]=0) or zero-extended zimm (funct3[2]=1):
- RW: src
- RS: old|src
- RC: old&~src
REQ-026 SHALL set do_write=1 for RW/RWI always.
REQ-027 SHALL set do_write=1 for RS/RC/RSI/RCI only when rs1_idx!=0.
REQ-028 SHALL treat a request as illegal in any of these cases:
- funct3 is 0 or 4.
- addr is not one of 0xB00, 0xB80, 0xB02, 0xB82, 0xF11, 0xF12, 0x301.
- do_write=1 and addr[11:10]==2'b11 (read-only).
REQ-029 From READ, SHALL go to RESP if illegal or do_write=0, else to WRITE.
REQ-030 In WRITE, SHALL assert csr_wen=1 for exactly one cycle, with csr_addr=latched addr and csr_wdata=new, then go to RESP.
REQ-031 In RESP, SHALL hold rsp_valid=1 with stable rsp_rd, rsp_data=old, and rsp_illegal until rsp_ready=1, then return to IDLE.
REQ-032 When rsp_illegal=1, SHALL drive rsp_data=0 and SHALL NOT have asserted csr_wen.
REQ-033 Write latency: accept at edge T, csr_wen high in cycle T+2, rsp_valid first high in cycle T+3.
REQ-034 Non-write latency: rsp_valid first high in cycle T+2.
REQ-035 SHALL keep csr_wen=0 in every state except WRITE.
REQ-036 Outside WRITE, SHALL drive csr_wdata=0.
REQ-037 SHALL drive csr_addr with the latched address in every state.
REQ-038 SHALL keep throughput at one instruction per 3 or 4 cycles, with no overlap.

Reset
REQ-039 Reset SHALL force state=IDLE.
REQ-040 Reset SHALL force these values:
- req_ready=1
- csr_wen=0
- csr_addr=0
- csr_wdata=0
- rsp_valid=0
- rsp_rd=0
- rsp_data=0
- rsp_illegal=0
- all latches 0
REQ-041 Reset asserted in READ, WRITE or RESP SHALL abort the instruction immediately, with no further csr_wen and no response.

Structure
REQ-042 SHALL place the funct3 encodings, CSR address constants and the state enum in a shared package csr_defines, also used by csr.
REQ-043 SHALL take REG_W_END from reg_defines.
REQ-044 SHALL keep the combinational new-value/legality logic in one sub-module, csr_alu: inputs funct3, old, rs1, zimm, addr; outputs new, do_write, illegal.

Verification
REQ-045 The bench SHALL cover these directed scenarios:
- CSRRW addr 0xB00, rs1=0x1234, csr_rdata=0x50 -> csr_wen at T+2 with wdata 0x1234; rsp_data=0x50 at T+3.
- CSRRS addr 0xB02, rs1_idx=0 -> no csr_wen; rsp_valid at T+2 with old value; rsp_illegal=0.
- CSRRCI addr 0xB80, zimm=5, old=0xF -> wdata=0xA.
- CSRRW addr 0xF11 -> rsp_illegal=1, rsp_data=0, no csr_wen.
- CSRRS addr 0x7C0 -> rsp_illegal=1.
- rsp_ready held low 5 cycles -> rsp outputs stable, req_ready=0.
- Reset pulsed in WRITE -> csr_wen=0 immediately, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/csr_defines.sv
// Zicsr encodings, implemented CSR addresses and the CSR executor state type.
package csr_defines;

    localparam logic [2:0] F3_RW  = 3'd1;
    localparam logic [2:0] F3_RS  = 3'd2;
    localparam logic [2:0] F3_RC  = 3'd3;
    localparam logic [2:0] F3_RWI = 3'd5;
    localparam logic [2:0] F3_RSI = 3'd6;
    localparam logic [2:0] F3_RCI = 3'd7;

    localparam logic [11:0] CSR_CYCLE     = 12'hB00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_INSTRET   = 12'hB02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MISA      = 12'h301;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_state_e;

    function automatic logic csr_addr_known(input logic [11:0] addr);
        return addr inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
                            CSR_MVENDORID, CSR_MARCHID, CSR_MISA};
    endfunction

endpackage

// File: rtl/reg_defines.sv
// Register-file wide constants shared across the core.
package reg_defines;

    localparam int REG_W_END = 31;

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value, write-enable and legality decision for one CSR instruction.
module csr_alu
    import csr_defines::*;
#(
    parameter int REG_W = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [REG_W-1:0] old_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [4:0]       zimm_i,
    input  logic [11:0]      addr_i,
    output logic [REG_W-1:0] new_o,
    output logic             do_write_o,
    output logic             illegal_o
);

    logic [REG_W-1:0] src;
    logic             op_bad;

    always_comb begin
        src        = funct3_i[2] ? {{(REG_W-5){1'b0}}, zimm_i} : rs1_i;
        new_o      = '0;
        do_write_o = 1'b0;
        op_bad     = 1'b0;
        case (funct3_i)
            F3_RW, F3_RWI: begin
                new_o      = src;
                do_write_o = 1'b1;
            end
            F3_RS, F3_RSI: begin
                new_o      = old_i | src;
                do_write_o = (zimm_i != 5'd0);
            end
            F3_RC, F3_RCI: begin
                new_o      = old_i & ~src;
                do_write_o = (zimm_i != 5'd0);
            end
            default: op_bad = 1'b1;
        endcase
        // Top two address bits 2'b11 mark a read-only CSR.
        illegal_o = op_bad || !csr_addr_known(addr_i)
                    || (do_write_o && (addr_i[11:10] == 2'b11));
    end

endmodule

// File: rtl/csr_exec.sv
// Sequential executor for Zicsr instructions: read, optional write, then hold a response.
//   state | meaning
//   IDLE  | ready for a new instruction
//   READ  | sample old CSR value, decide write/legality
//   WRITE | one-cycle CSR write strobe
//   RESP  | hold result until consumer takes it
module csr_exec
    import csr_defines::*;
#(
    parameter int REG_W = reg_defines::REG_W_END + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [11:0]      req_addr,
    input  logic [REG_W-1:0] req_rs1,
    input  logic [4:0]       req_rs1_idx,
    input  logic [4:0]       req_rd,
    output logic [11:0]      csr_addr,
    output logic             csr_wen,
    output logic [REG_W-1:0] csr_wdata,
    input  logic [REG_W-1:0] csr_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_rd,
    output logic [REG_W-1:0] rsp_data,
    output logic             rsp_illegal
);

    csr_state_e       state_q, state_d;
    logic [2:0]       funct3_q;
    logic [11:0]      addr_q;
    logic [REG_W-1:0] rs1_q;
    logic [4:0]       rs1_idx_q;
    logic [4:0]       rd_q;
    logic [REG_W-1:0] old_q;
    logic [REG_W-1:0] new_q;
    logic             illegal_q;

    logic [REG_W-1:0] alu_new;
    logic             alu_do_write;
    logic             alu_illegal;

    csr_alu #(.REG_W(REG_W)) u_alu (
        .funct3_i   (funct3_q),
        .old_i      (csr_rdata),
        .rs1_i      (rs1_q),
        .zimm_i     (rs1_idx_q),
        .addr_i     (addr_q),
        .new_o      (alu_new),
        .do_write_o (alu_do_write),
        .illegal_o  (alu_illegal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_q     <= '0;
            rs1_idx_q <= '0;
            rd_q      <= '0;
            old_q     <= '0;
            new_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                funct3_q  <= req_funct3;
                addr_q    <= req_addr;
                rs1_q     <= req_rs1;
                rs1_idx_q <= req_rs1_idx;
                rd_q      <= req_rd;
            end
            if (state_q == READ) begin
                old_q     <= csr_rdata;
                new_q     <= alu_new;
                illegal_q <= alu_illegal;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        csr_addr    = addr_q;
        csr_wen     = 1'b0;
        csr_wdata   = '0;
        rsp_valid   = 1'b0;
        rsp_rd      = rd_q;
        rsp_data    = '0;
        rsp_illegal = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = READ;
            end
            READ: begin
                state_d = (alu_illegal || !alu_do_write) ? RESP : WRITE;
            end
            WRITE: begin
                csr_wen   = 1'b1;
                csr_wdata = new_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_illegal = illegal_q;
                // Illegal instructions never leak the CSR contents.
                rsp_data    = illegal_q ? '0 : old_q;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_exec.sv
// Bench for csr_exec: directed Zicsr scenarios plus random instructions against a CSR-level model.
module tb_csr_exec;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1;
    logic [4:0]  req_rs1_idx;
    logic [4:0]  req_rd;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    logic [31:0] mem [4096];
    int n_cmp = 0;
    int n_mis = 0;

    assign csr_rdata = mem[csr_addr];

    always #5 clock = ~clock;

    csr_exec dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_rs1     (req_rs1),
        .req_rs1_idx (req_rs1_idx),
        .req_rd      (req_rd),
        .csr_addr    (csr_addr),
        .csr_wen     (csr_wen),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd      (rsp_rd),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of a CSR instruction, derived from the Zicsr rules.
    function automatic void model(input logic [2:0] f3, input logic [11:0] a,
                                  input logic [31:0] rs1v, input logic [4:0] idx,
                                  input logic [31:0] old,
                                  output bit wr, output bit ill, output logic [31:0] nv);
        logic [31:0] src;
        int kind;
        bit known;
        known = (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82)
             || (a == 12'hF11) || (a == 12'hF12) || (a == 12'h301);
        src  = (f3 >= 3'd5) ? 32'(idx) : rs1v;
        kind = int'(f3) % 4;
        if (kind == 1)      nv = src;
        else if (kind == 2) nv = old | src;
        else                nv = old & ~src;
        wr  = (kind == 1) || (idx != 5'd0);
        ill = (kind == 0) || !known || (wr && a >= 12'hC00);
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1v,
                          input logic [4:0] idx, input logic [4:0] rdv, input int hold);
        logic [31:0] old, nv, exp_data;
        bit wr, ill, wexp;
        old = mem[a];
        model(f3, a, rs1v, idx, old, wr, ill, nv);
        wexp     = wr && !ill;
        exp_data = ill ? 32'd0 : old;

        req_valid = 1'b1; req_funct3 = f3; req_addr = a;
        req_rs1 = rs1v; req_rs1_idx = idx; req_rd = rdv;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        // Scramble request fields to prove they were captured at acceptance.
        req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = 12'($urandom);
        req_rs1 = $urandom; req_rs1_idx = 5'($urandom); req_rd = 5'($urandom);
        chk("read_req_ready", 32'(req_ready), 32'd0);
        chk("read_wen", 32'(csr_wen), 32'd0);
        chk("read_wdata", csr_wdata, 32'd0);
        chk("read_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("read_addr", 32'(csr_addr), 32'(a));
        @(posedge clock); #1;
        if (wexp) begin
            chk("write_wen", 32'(csr_wen), 32'd1);
            chk("write_wdata", csr_wdata, nv);
            chk("write_addr", 32'(csr_addr), 32'(a));
            chk("write_rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clock); #1;
        end
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", 32'(rsp_valid), 32'd1);
            chk("resp_rd", 32'(rsp_rd), 32'(rdv));
            chk("resp_data", rsp_data, exp_data);
            chk("resp_illegal", 32'(rsp_illegal), 32'(ill));
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            chk("resp_wen", 32'(csr_wen), 32'd0);
            chk("resp_wdata", csr_wdata, 32'd0);
            chk("resp_addr", 32'(csr_addr), 32'(a));
            if (i == hold) rsp_ready = 1'b1;
            @(posedge clock); #1;
        end
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_req_ready", 32'(req_ready), 32'd1);
        chk("done_wen", 32'(csr_wen), 32'd0);
        if (wexp) mem[a] = nv;
    endtask

    initial begin
        logic [11:0] addr_pool [9];
        addr_pool = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                      12'hF12, 12'h301, 12'h7C0, 12'hC00};
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_rs1_idx = '0; req_rd = '0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wen", 32'(csr_wen), 32'd0);
        chk("rst_addr", 32'(csr_addr), 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        #6 reset = 1'b0;
        @(posedge clock); #1;

        mem[12'hB00] = 32'h50;
        run_op(3'd1, 12'hB00, 32'h1234, 5'd3, 5'd7, 0);
        chk("dir_rw_result", mem[12'hB00], 32'h1234);
        run_op(3'd2, 12'hB02, 32'hFFFF_FFFF, 5'd0, 5'd9, 0);
        mem[12'hB80] = 32'hF;
        run_op(3'd7, 12'hB80, 32'h0, 5'd5, 5'd1, 1);
        chk("dir_rci_result", mem[12'hB80], 32'hA);
        run_op(3'd1, 12'hF11, 32'hDEAD_BEEF, 5'd4, 5'd2, 0);
        run_op(3'd2, 12'h7C0, 32'h1, 5'd6, 5'd3, 0);
        run_op(3'd6, 12'h301, 32'h0, 5'd12, 5'd31, 5);
        run_op(3'd0, 12'hB00, 32'h5, 5'd1, 5'd4, 0);
        run_op(3'd4, 12'hB82, 32'h5, 5'd1, 5'd5, 0);
        run_op(3'd2, 12'hF12, 32'h1, 5'd0, 5'd6, 0);

        // Abort an instruction by reset while its write strobe is live.
        req_valid = 1'b1; req_funct3 = 3'd1; req_addr = 12'hB82;
        req_rs1 = 32'hCAFE; req_rs1_idx = 5'd8; req_rd = 5'd10;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("abort_wen_before", 32'(csr_wen), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_wen", 32'(csr_wen), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_wdata", csr_wdata, 32'd0);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_post_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("abort_post_wen", 32'(csr_wen), 32'd0);
            chk("abort_post_req_ready", 32'(req_ready), 32'd1);
        end

        for (int n = 0; n < 40; n++) begin
            logic [4:0] idx;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(3'($urandom_range(0, 7)), addr_pool[$urandom_range(0, 8)], $urandom,
                   idx, 5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
